cache_req_arbiter: RTL and testbench

- Round-robin arbiter that shares one cache_controller among NREQ requesters (for example, CPU ports or a DMA engine).
- Latches the winning request's tag and rw, then pulses the controller start.
- Waits for the controller's completion pulse, then routes the hit result back to the winner.
- Sits between the requester ports and the cache_controller start/read_write/tag_in inputs.

---
 rtl/cache_req_arbiter_if.sv | 32 +++
 rtl/cache_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_cache_req_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_req_arbiter_if.sv
// Requester/controller bundle shared by cache_req_arbiter and its environment.
// slave = arbiter side, master = requesters plus cache controller side.
interface cache_req_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_rw;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic                  rsp_hit;
    logic                  rsp_err;
    logic                  busy;
    logic                  cache_start;
    logic                  cache_rw;
    logic [TAG_W-1:0]      cache_tag;
    logic                  cache_done;
    logic                  cache_hit;

    modport master (
        output req, req_rw, req_tag, cache_done, cache_hit,
        input  gnt, rsp_valid, rsp_hit, rsp_err, busy,
        input  cache_start, cache_rw, cache_tag
    );

    modport slave (
        input  req, req_rw, req_tag, cache_done, cache_hit,
        output gnt, rsp_valid, rsp_hit, rsp_err, busy,
        output cache_start, cache_rw, cache_tag
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache controller among NREQ requesters.
// Optional WAIT-state watchdog enabled by defining ARB_TIMEOUT_EN.
module cache_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TAG_W   = 8,
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    cache_req_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    cur_id;
    logic [IDW-1:0]    pick_id;
    logic              pick_ok;
    logic [IDW:0]      scan;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic              rsp_hit_q;
    logic              busy_q;
    logic              start_q;
    logic              rw_q;
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  tags [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_tags
        assign tags[k] = bus.req_tag[k*TAG_W +: TAG_W];
    end

    // First set req bit at or above rr_ptr, wrapping through NREQ-1 to 0.
    always_comb begin
        pick_id = '0;
        pick_ok = 1'b0;
        scan    = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (scan >= (IDW+1)'(NREQ))
                scan = scan - (IDW+1)'(NREQ);
            if (!pick_ok && bus.req[scan[IDW-1:0]]) begin
                pick_ok = 1'b1;
                pick_id = scan[IDW-1:0];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt;
    logic       rsp_err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_id      <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_hit_q   <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            rw_q        <= 1'b0;
            tag_q       <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        cur_id  <= pick_id;
                        rw_q    <= bus.req_rw[pick_id];
                        tag_q   <= tags[pick_id];
                        gnt_q   <= NREQ'(1) << pick_id;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt_q   <= '0;
                    start_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state   <= WAIT;
                end
                WAIT: begin
                    if (bus.cache_done) begin
                        rsp_hit_q   <= bus.cache_hit;
                        rsp_valid_q <= NREQ'(1) << cur_id;
`ifdef ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= RESP;
`ifdef ARB_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LIM) begin
                        rsp_hit_q   <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= NREQ'(1) << cur_id;
                        state       <= RESP;
                    end else begin
                        tmo_cnt     <= tmo_cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    rr_ptr      <= (cur_id == IDW'(NREQ - 1)) ?
                                   '0 : cur_id + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_hit     = rsp_hit_q;
    assign bus.busy        = busy_q;
    assign bus.cache_start = start_q;
    assign bus.cache_rw    = rw_q;
    assign bus.cache_tag   = tag_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.rsp_err     = rsp_err_q;
`else
    assign bus.rsp_err     = 1'b0;
`endif
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed testbench for cache_req_arbiter (NREQ=4, TAG_W=8, TIMEOUT=16).
// Covers ARB_TIMEOUT_EN both defined and undefined.
module tb_cache_req_arbiter;
    localparam int NREQ    = 4;
    localparam int TAG_W   = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cache_req_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus ();

    cache_req_arbiter #(
        .NREQ(NREQ), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 4 && bus.gnt == '0; i++) step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_rw = '0; bus.req_tag = '0;
        bus.cache_done = 1'b0; bus.cache_hit = 1'b0;
        rst = 1'b1;
        step(); step();
        checks++;
        if ({bus.gnt, bus.rsp_valid, bus.rsp_hit, bus.rsp_err, bus.busy,
             bus.cache_start, bus.cache_rw, bus.cache_tag} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b rsp_valid=%b busy=%b tag=%h want all 0",
                     bus.gnt, bus.rsp_valid, bus.busy, bus.cache_tag);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b gnt=%b want 0/0000", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_single();
        bus.req_rw = 4'b0010; bus.req_tag = 32'h0000_5A00; bus.req = 4'b0010;
        step();
        checks++;
        if (bus.gnt !== 4'b0010 || bus.cache_start !== 1'b1) begin
            failures++;
            $display("FAIL single_gnt: gnt=%b start=%b want 0010/1", bus.gnt, bus.cache_start);
        end
        checks++;
        if (bus.cache_tag !== 8'h5A || bus.cache_rw !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_latch: tag=%h rw=%b busy=%b want 5a/1/1",
                     bus.cache_tag, bus.cache_rw, bus.busy);
        end
        bus.req = '0; bus.req_tag = '0; bus.req_rw = '0;
        step();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.cache_start !== 1'b0 ||
            bus.cache_tag !== 8'h5A || bus.cache_rw !== 1'b1) begin
            failures++;
            $display("FAIL single_wait_hold: gnt=%b start=%b tag=%h rw=%b want 0000/0/5a/1",
                     bus.gnt, bus.cache_start, bus.cache_tag, bus.cache_rw);
        end
        step(); step();
        bus.cache_done = 1'b1; bus.cache_hit = 1'b1;
        step();
        bus.cache_done = 1'b0; bus.cache_hit = 1'b0;
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_hit !== 1'b1 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp: valid=%b hit=%b err=%b want 0010/1/0",
                     bus.rsp_valid, bus.rsp_hit, bus.rsp_err);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.rsp_hit !== 1'b1) begin
            failures++;
            $display("FAIL single_after: valid=%b busy=%b hit=%b want 0000/0/1",
                     bus.rsp_valid, bus.busy, bus.rsp_hit);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp;
        apply_reset();
        bus.req_tag = 32'h4433_2211; bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp = 4'(1 << k);
            wait_gnt();
            checks++;
            if (bus.gnt !== exp || bus.cache_tag !== 8'(8'h11 * (k + 1))) begin
                failures++;
                $display("FAIL contention_gnt%0d: gnt=%b tag=%h want %b/%h", k,
                         bus.gnt, bus.cache_tag, exp, 8'(8'h11 * (k + 1)));
            end
            bus.req[k] = 1'b0;
            step();
            bus.cache_done = 1'b1; bus.cache_hit = 1'(k);
            step();
            bus.cache_done = 1'b0;
            checks++;
            if (bus.rsp_valid !== exp || bus.rsp_hit !== 1'(k)) begin
                failures++;
                $display("FAIL contention_rsp%0d: valid=%b hit=%b want %b/%b", k,
                         bus.rsp_valid, bus.rsp_hit, exp, 1'(k));
            end
            step();
        end
        bus.req = 4'b1001;
        wait_gnt();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL contention_wrap: gnt=%b want 0001", bus.gnt);
        end
        bus.req = '0;
        step();
        bus.cache_done = 1'b1;
        step();
        bus.cache_done = 1'b0;
        step();
    endtask

    task automatic test_rotation();
        bus.req = 4'b0100;
        wait_gnt();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL rotation_first: gnt=%b want 0100", bus.gnt);
        end
        bus.req = '0;
        step();
        bus.cache_done = 1'b1;
        step();
        bus.cache_done = 1'b0;
        step();
        bus.req = 4'b0101;
        wait_gnt();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL rotation_wrap: gnt=%b want 0001", bus.gnt);
        end
        bus.req = 4'b0100;
        step();
        bus.cache_done = 1'b1;
        step();
        bus.cache_done = 1'b0;
        step();
        wait_gnt();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL rotation_second: gnt=%b want 0100", bus.gnt);
        end
        bus.req = '0;
        step();
        bus.cache_done = 1'b1; bus.cache_hit = 1'b1;
        step();
        bus.cache_done = 1'b0; bus.cache_hit = 1'b0;
        step();
    endtask

    task automatic test_spurious_done();
        bus.cache_done = 1'b1;
        step();
        bus.cache_done = 1'b0;
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL spurious_idle: valid=%b busy=%b want 0000/0", bus.rsp_valid, bus.busy);
        end
        bus.req = 4'b0010;
        step();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL spurious_gnt: gnt=%b want 0010", bus.gnt);
        end
        bus.req = '0; bus.cache_done = 1'b1;
        step();
        bus.cache_done = 1'b0;
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL spurious_issue: valid=%b busy=%b want 0000/1", bus.rsp_valid, bus.busy);
        end
        step(); step();
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL spurious_wait: valid=%b busy=%b want 0000/1", bus.rsp_valid, bus.busy);
        end
        bus.cache_done = 1'b1; bus.cache_hit = 1'b0;
        step();
        bus.cache_done = 1'b0;
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_hit !== 1'b0) begin
            failures++;
            $display("FAIL spurious_rsp: valid=%b hit=%b want 0010/0", bus.rsp_valid, bus.rsp_hit);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.req_tag = 32'hC300_0000; bus.req_rw = 4'b1000; bus.req = 4'b1000;
        step();
        checks++;
        if (bus.gnt !== 4'b1000 || bus.cache_tag !== 8'hC3) begin
            failures++;
            $display("FAIL midrst_gnt: gnt=%b tag=%h want 1000/c3", bus.gnt, bus.cache_tag);
        end
        bus.req = '0; bus.req_rw = '0; bus.req_tag = '0;
        step(); step();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.gnt, bus.rsp_valid, bus.rsp_hit, bus.rsp_err, bus.busy,
             bus.cache_start, bus.cache_rw, bus.cache_tag} !== '0) begin
            failures++;
            $display("FAIL midrst_async: busy=%b rw=%b tag=%h want all 0",
                     bus.busy, bus.cache_rw, bus.cache_tag);
        end
        bus.cache_done = 1'b1;
        step();
        bus.cache_done = 1'b0;
        bus.req = 4'b0100;
        step();
        rst = 1'b0;
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_norsp: valid=%b want 0000", bus.rsp_valid);
        end
        step();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL midrst_regrant: gnt=%b want 0100", bus.gnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.cache_start !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL issuerst_async: gnt=%b start=%b busy=%b want 0000/0/0",
                     bus.gnt, bus.cache_start, bus.busy);
        end
        bus.req = 4'b1001;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL issuerst_rrptr: gnt=%b want 0001", bus.gnt);
        end
        bus.req = '0;
        step();
        bus.cache_done = 1'b1;
        step();
        bus.cache_done = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        bit early;
        apply_reset();
        bus.req = 4'b0001;
        step();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL timeout_gnt: gnt=%b want 0001", bus.gnt);
        end
        bus.req = '0;
`ifdef ARB_TIMEOUT_EN
        early = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (bus.rsp_valid != '0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: rsp_valid seen before cycle 17");
        end
        step();
        checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b1 || bus.rsp_hit !== 1'b0) begin
            failures++;
            $display("FAIL timeout_rsp: valid=%b err=%b hit=%b want 0001/1/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_hit);
        end
        step();
        bus.req = 4'b0010;
        step();
        bus.req = '0;
        for (int i = 1; i <= 16; i++) step();
        bus.cache_done = 1'b1; bus.cache_hit = 1'b1;
        step();
        bus.cache_done = 1'b0; bus.cache_hit = 1'b0;
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_err !== 1'b0 || bus.rsp_hit !== 1'b1) begin
            failures++;
            $display("FAIL timeout_done_wins: valid=%b err=%b hit=%b want 0010/0/1",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_hit);
        end
        step();
`else
        early = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.rsp_valid != '0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0 || bus.busy !== 1'b1 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout: rsp_seen=%b busy=%b err=%b want 0/1/0",
                     early, bus.busy, bus.rsp_err);
        end
        apply_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_rotation();
        test_spurious_done();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
